// File: rtl/par_mem_2p_pkg.sv
// Shared types, default sizes and the parity helper for the parity-protected
// dual-port memory (optional error injection: PAR_MEM_ERR_INJ_EN).
package par_mem_2p_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 16;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } mem_state_e;

   // Zero-extension leaves the XOR reduction unchanged, so any width up to 64 fits.
   function automatic logic parity_f(input logic [63:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/par_mem_init_seq.sv
// Post-reset init sequencer: walks every address once, then holds READY.
// Part of par_mem_2p (optional error injection: PAR_MEM_ERR_INJ_EN).
module par_mem_init_seq
   import par_mem_2p_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy,
   output logic              init_done,
   output logic              init_we,
   output logic [ADDR_W-1:0] init_addr
);

   mem_state_e        r_state;
   logic [ADDR_W-1:0] r_init_ptr;

   // Init FSM: one location cleared per cycle, READY after the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= INIT;
         r_init_ptr <= '0;
      end else begin
         case (r_state)
            INIT: begin
               r_init_ptr <= r_init_ptr + 1'b1;
               if (r_init_ptr == ADDR_W'(DEPTH - 1)) begin
                  r_state <= READY;
               end else begin
                  r_state <= INIT;
               end
            end
            READY: begin
               r_state    <= READY;
               r_init_ptr <= r_init_ptr;
            end
            default: begin
               r_state    <= INIT;
               r_init_ptr <= '0;
            end
         endcase
      end
   end

   assign busy      = (r_state == INIT);
   assign init_done = (r_state == READY);
   assign init_we   = (r_state == INIT);
   assign init_addr = r_init_ptr;

endmodule

// File: rtl/par_mem_2p.sv
// Parity-protected simple dual-port memory with init sequencer and saturating
// parity-error counter. Define PAR_MEM_ERR_INJ_EN to add the inj_en port.
module par_mem_2p
   import par_mem_2p_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
`ifdef PAR_MEM_ERR_INJ_EN
   input  logic              inj_en,
`endif
   output logic [DATA_W:0]   rd_data,
   output logic              rd_valid,
   output logic              par_err,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              busy,
   output logic              init_done
);

   logic [DATA_W:0]   r_mem [DEPTH];
   logic [DATA_W:0]   r_rd_data;
   logic              r_rd_valid;
   logic [CNT_W-1:0]  r_err_cnt;

   logic              w_busy;
   logic              w_init_done;
   logic              w_init_we;
   logic [ADDR_W-1:0] w_init_addr;
   logic              w_wr_in_range;
   logic              w_rd_in_range;
   logic              w_wr_ok;
   logic              w_rd_ok;
   logic              w_collide;
   logic              w_inj;
   logic [DATA_W:0]   w_wr_word;
   logic              w_par_err;

   par_mem_init_seq #(.DEPTH(DEPTH)) u_init_seq (
      .clk       (clk),
      .rst       (rst),
      .busy      (w_busy),
      .init_done (w_init_done),
      .init_we   (w_init_we),
      .init_addr (w_init_addr)
   );

   // Range checks only exist when DEPTH leaves unused address codes.
   generate
      if ((2 ** ADDR_W) == DEPTH) begin : g_pow2
         assign w_wr_in_range = 1'b1;
         assign w_rd_in_range = 1'b1;
      end else begin : g_npow2
         assign w_wr_in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
         assign w_rd_in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));
      end
   endgenerate

`ifdef PAR_MEM_ERR_INJ_EN
   assign w_inj = inj_en;
`else
   assign w_inj = 1'b0;
`endif

   assign w_wr_ok   = wr_en & ~w_busy & w_wr_in_range;
   assign w_rd_ok   = rd_en & ~w_busy;
   assign w_collide = w_wr_ok & (wr_addr == rd_addr);
   assign w_wr_word = {parity_f(64'(wr_data)) ^ w_inj, wr_data};

   // Array write port: the init sequencer owns it until READY.
   always_ff @(posedge clk) begin
      if (w_init_we) begin
         r_mem[w_init_addr] <= '0;
      end else if (w_wr_ok) begin
         r_mem[wr_addr] <= w_wr_word;
      end else begin
         r_mem[wr_addr] <= r_mem[wr_addr];
      end
   end

   // Read port, write-first on same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_ok;
         if (!w_rd_ok) begin
            r_rd_data <= r_rd_data;
         end else if (w_collide) begin
            r_rd_data <= w_wr_word;
         end else if (w_rd_in_range) begin
            r_rd_data <= r_mem[rd_addr];
         end else begin
            r_rd_data <= '0;
         end
      end
   end

   assign w_par_err = r_rd_valid & (r_rd_data[DATA_W] != parity_f(64'(r_rd_data[DATA_W-1:0])));

   // Saturating parity-error counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (w_par_err && (r_err_cnt != {CNT_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end else begin
         r_err_cnt <= r_err_cnt;
      end
   end

   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign par_err   = w_par_err;
   assign err_cnt   = r_err_cnt;
   assign busy      = w_busy;
   assign init_done = w_init_done;

endmodule

// File: tb/tb_par_mem_2p.sv
// Self-checking bench for par_mem_2p; the inj tests compile in when
// PAR_MEM_ERR_INJ_EN is defined.
module tb_par_mem_2p;
   import par_mem_2p_pkg::*;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 8;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              rd_en = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              inj_en = 1'b0;
   logic [DATA_W:0]   rd_data;
   logic              rd_valid;
   logic              par_err;
   logic [CNT_W-1:0]  err_cnt;
   logic              busy;
   logic              init_done;

   int checks = 0;
   int errors = 0;

   logic [DATA_W:0] exp_mem [DEPTH];
   logic [DATA_W:0] exp_data;
   logic            exp_valid;
   logic            exp_perr;
   int              exp_cnt;
   bit              model_ready;

   par_mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
`ifdef PAR_MEM_ERR_INJ_EN
      .inj_en    (inj_en),
`endif
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .par_err   (par_err),
      .err_cnt   (err_cnt),
      .busy      (busy),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      exp_data    = '0;
      exp_valid   = 1'b0;
      exp_perr    = 1'b0;
      exp_cnt     = 0;
      model_ready = 1'b0;
   endtask

   // One clock of stimulus; the model predicts the outputs seen after the edge.
   task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic re, input logic [ADDR_W-1:0] ra, input logic inj);
      logic [DATA_W:0] word;
      wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra; inj_en = inj;
      if (exp_perr && exp_cnt < 255) exp_cnt++;
      word = {parity_f(64'(wd)), wd};
`ifdef PAR_MEM_ERR_INJ_EN
      if (inj) word[DATA_W] = ~word[DATA_W];
`endif
      exp_valid = model_ready && re;
      if (exp_valid) exp_data = (we && wa == ra) ? word : exp_mem[ra];
      if (model_ready && we) exp_mem[wa] = word;
      exp_perr = exp_valid && (exp_data[DATA_W] != (^exp_data[DATA_W-1:0]));
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; inj_en = 1'b0;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (busy && n < 40) begin
         step(1'b0, '0, '0, 1'b0, '0, 1'b0);
         n++;
      end
      model_ready = 1'b1;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1; model_reset(); #2;
      checks++; if (rd_data !== 9'h000 || rd_valid !== 1'b0 || par_err !== 1'b0) begin
         errors++; $display("FAIL reset_rd act=%h/%b/%b exp=000/0/0", rd_data, rd_valid, par_err); end
      checks++; if (err_cnt !== 8'd0 || busy !== 1'b1 || init_done !== 1'b0) begin
         errors++; $display("FAIL reset_ctl act=%0d/%b/%b exp=0/1/0", err_cnt, busy, init_done); end
      @(posedge clk); #1; rst = 1'b0;
      wait_init(n);
      checks++; if (n !== 16) begin errors++; $display("FAIL init_len act=%0d exp=16", n); end
      checks++; if (busy !== 1'b0 || init_done !== 1'b1) begin
         errors++; $display("FAIL init_flags act=%b/%b exp=0/1", busy, init_done); end
      step(1'b0, '0, '0, 1'b1, 4'd5, 1'b0);
      checks++; if (rd_data !== 9'h000 || rd_valid !== 1'b1 || par_err !== 1'b0) begin
         errors++; $display("FAIL init_rd5 act=%h/%b/%b exp=000/1/0", rd_data, rd_valid, par_err); end
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      checks++; if (rd_valid !== 1'b0 || rd_data !== 9'h000) begin
         errors++; $display("FAIL rd_pulse act=%b/%h exp=0/000", rd_valid, rd_data); end
   endtask

   task automatic test_basic();
      step(1'b1, 4'd3, 8'h07, 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd3, 1'b0);
      checks++; if (rd_data !== 9'h107 || rd_valid !== 1'b1 || par_err !== 1'b0) begin
         errors++; $display("FAIL basic_a3 act=%h/%b/%b exp=107/1/0", rd_data, rd_valid, par_err); end
      step(1'b1, 4'd15, 8'hA5, 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd15, 1'b0);
      checks++; if (rd_data !== 9'h0A5 || par_err !== 1'b0) begin
         errors++; $display("FAIL basic_a15 act=%h/%b exp=0a5/0", rd_data, par_err); end
   endtask

   task automatic test_collision();
      step(1'b1, 4'd2, 8'h3C, 1'b0, '0, 1'b0);
      step(1'b1, 4'd2, 8'h81, 1'b1, 4'd2, 1'b0);
      checks++; if (rd_data !== 9'h081 || rd_valid !== 1'b1) begin
         errors++; $display("FAIL collision act=%h/%b exp=081/1", rd_data, rd_valid); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 1'b0);
         checks++; if (rd_valid !== exp_valid || rd_data !== exp_data || par_err !== exp_perr
                       || err_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL random[%0d] act=%b/%h/%b/%0d exp=%b/%h/%b/%0d", i, rd_valid, rd_data,
                     par_err, err_cnt, exp_valid, exp_data, exp_perr, exp_cnt);
         end
      end
   endtask

`ifdef PAR_MEM_ERR_INJ_EN
   task automatic test_err_inj();
      step(1'b1, 4'd1, 8'h01, 1'b0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b1, 4'd1, 1'b0);
      checks++; if (rd_data !== 9'h001 || par_err !== 1'b1) begin
         errors++; $display("FAIL inj_rd act=%h/%b exp=001/1", rd_data, par_err); end
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL inj_cnt1 act=%0d exp=1", err_cnt); end
      step(1'b1, 4'd6, 8'h10, 1'b1, 4'd6, 1'b1);
      checks++; if (rd_data !== 9'h010 || par_err !== 1'b1) begin
         errors++; $display("FAIL inj_coll act=%h/%b exp=010/1", rd_data, par_err); end
      for (int i = 0; i < 300; i++) step(1'b0, '0, '0, 1'b1, 4'd1, 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      checks++; if (err_cnt !== 8'd255 || exp_cnt != 255) begin
         errors++; $display("FAIL inj_sat act=%0d exp=255", err_cnt); end
   endtask
`endif

   task automatic test_access_during_init();
      int n;
      rst = 1'b1; model_reset(); #2;
      @(posedge clk); #1; rst = 1'b0;
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      step(1'b1, 4'd4, 8'hFF, 1'b1, 4'd4, 1'b0);
      checks++; if (rd_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL init_access act=%b/%b exp=0/1", rd_valid, busy); end
      wait_init(n);
      step(1'b0, '0, '0, 1'b1, 4'd4, 1'b0);
      checks++; if (rd_data !== 9'h000 || rd_valid !== 1'b1) begin
         errors++; $display("FAIL init_a4 act=%h/%b exp=000/1", rd_data, rd_valid); end
   endtask

   task automatic test_reset_mid();
      int n;
      step(1'b1, 4'd3, 8'h5A, 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 4'd3, 1'b0);
      #2; rst = 1'b1; model_reset(); #1;
      checks++; if (rd_valid !== 1'b0 || rd_data !== 9'h000 || par_err !== 1'b0 || err_cnt !== 8'd0) begin
         errors++; $display("FAIL mid_rst_rd act=%b/%h/%b/%0d exp=0/000/0/0", rd_valid, rd_data, par_err, err_cnt); end
      checks++; if (busy !== 1'b1 || init_done !== 1'b0) begin
         errors++; $display("FAIL mid_rst_ctl act=%b/%b exp=1/0", busy, init_done); end
      @(posedge clk); #1; rst = 1'b0;
      wait_init(n);
      checks++; if (n !== 16) begin errors++; $display("FAIL mid_init_len act=%0d exp=16", n); end
      step(1'b0, '0, '0, 1'b1, 4'd3, 1'b0);
      checks++; if (rd_data !== 9'h000 || rd_valid !== 1'b1) begin
         errors++; $display("FAIL mid_a3 act=%h/%b exp=000/1", rd_data, rd_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_collision();
      test_random();
`ifdef PAR_MEM_ERR_INJ_EN
      test_err_inj();
`endif
      test_access_during_init();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
